// File: rtl/mem_loader_pkg.sv
// Shared definitions for the run-time memory loader: FSM states and the
// byte-to-word packing rule that the file-initialised ROM also follows.
package mem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Bytes per word; the top byte is truncated when width is not a multiple of 8.
  function automatic int bytes_per_word(input int data_w);
    return ((data_w - 1) / 8) + 1;
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Byte stream in, RAM write port out, bundled between the loader and its environment.
// Stream: a byte moves on every rising clk edge where s_valid && s_ready; the
// source holds s_data stable while s_valid is high and s_ready is low.
interface mem_loader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_loader_word_packer.sv
// Little-endian byte-to-word assembly: byte index bp lands in bits [bp*8 +: 8],
// with bits above DATA_W in the top byte dropped on the way out.
module mem_loader_word_packer
  import mem_loader_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [7:0]        i_byte,
  output logic [DATA_W-1:0] o_word_next,
  output logic              o_last
);

  localparam int BPW    = bytes_per_word(DATA_W);
  localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [BIDX_W-1:0] r_bidx;
  logic [BPW*8-1:0]  r_asm;
  logic [BPW*8-1:0]  w_asm_next;

  // Word as it will look once the byte on i_byte is inserted at the current lane.
  always_comb begin
    w_asm_next = r_asm;
    for (int b = 0; b < BPW; b++) begin
      if (r_bidx == BIDX_W'(b)) begin
        w_asm_next[b*8 +: 8] = i_byte;
      end
    end
  end

  assign o_word_next = w_asm_next[DATA_W-1:0];
  assign o_last      = (r_bidx == BIDX_W'(BPW - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_bidx <= '0;
      r_asm  <= '0;
    end else if (i_push) begin
      r_asm  <= w_asm_next;
      r_bidx <= o_last ? '0 : r_bidx + BIDX_W'(1);
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Fills a RAM image from a byte stream: collects BPW bytes per word, then issues
// one write at base+index (wrapping), and pulses o_done after the final word.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_word_count,
  input  logic              i_abort,
  mem_loader_if.master      bus,
  output logic              o_busy,
  output logic              o_done,
  output state_t            o_state
);

  generate
    if (DATA_W < 1) begin : g_bad_data_w
      $fatal(1, "mem_loader: DATA_W must be greater than zero");
    end
  endgenerate

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_widx;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_hs;
  logic              w_last_byte;
  logic              w_last_word;
  logic [DATA_W-1:0] w_word_next;

  // abort wins over a handshake presented in the same cycle.
  assign w_hs        = (r_state == COLLECT) && bus.s_valid && !i_abort;
  assign w_last_word = ({1'b0, r_widx} == (r_count - (ADDR_W+1)'(1)));

  mem_loader_word_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (r_state == IDLE),
    .i_push      (w_hs),
    .i_byte      (bus.s_data),
    .o_word_next (w_word_next),
    .o_last      (w_last_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    bus.s_ready = 1'b0;
    bus.mem_we  = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next = (i_word_count == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        bus.s_ready = 1'b1;
        o_busy      = 1'b1;
        if (i_abort) begin
          w_next = IDLE;
        end else if (w_hs && w_last_byte) begin
          w_next = WRITE;
        end
      end
      WRITE: begin
        o_busy = 1'b1;
        // A write coinciding with abort or reset is dropped.
        bus.mem_we = !i_abort && !rst;
        if (i_abort) begin
          w_next = IDLE;
        end else if (w_last_word) begin
          w_next = DONE;
        end else begin
          w_next = COLLECT;
        end
      end
      DONE: begin
        o_done = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Write address/data are registered on the final byte so they are stable
  // for the whole WRITE cycle and hold afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base      <= '0;
      r_count     <= '0;
      r_widx      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (r_state == IDLE && i_start) begin
        r_base  <= i_base_addr;
        r_count <= i_word_count;
        r_widx  <= '0;
      end
      if (w_hs && w_last_byte) begin
        r_mem_addr  <= r_base + r_widx;
        r_mem_wdata <= w_word_next;
      end
      if (r_state == WRITE && !i_abort && !w_last_word) begin
        r_widx <= r_widx + ADDR_W'(1);
      end
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign o_state       = r_state;

endmodule
